// File: rtl/apb_master_fsm_if.sv
// APB master bundle: local request side plus the APB bus and state observation.
// Latency: none, wiring only.
// Backpressure: pready from the slave stretches ACCESS; nothing flows back to the requester.
interface apb_master_fsm_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // local request side
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write_e;
    logic                  tr;
    // APB side
    logic                  psel;
    logic                  pready;
    logic [DATA_WIDTH-1:0] pdata;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite_e;
    logic                  penable;
    // observation
    logic [1:0]            present;
    logic [1:0]            next;

    modport master (
        input  data, addr, write_e, tr, psel, pready,
        output pdata, paddr, pwrite_e, penable, present, next
    );

    modport slave (
        output data, addr, write_e, tr, psel, pready,
        input  pdata, paddr, pwrite_e, penable, present, next
    );
endinterface

// File: rtl/apb_master_fsm.sv
// APB master sequencer: IDLE -> SETUP -> ACCESS, capturing addr/data/dir on SETUP entry.
// Latency: request seen in IDLE reaches SETUP on the next edge, ACCESS one edge later.
// Backpressure: pready low holds ACCESS indefinitely; tr is only sampled in IDLE or at ACCESS completion.
module apb_master_fsm #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    apb_master_fsm_if.master  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,    paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q,    pdata_d;
    logic                  pwrite_e_q, pwrite_e_d;

    // psel is a reserved qualifier; it is deliberately kept out of every path
    logic psel_unused;
    assign psel_unused = bus.psel;

    // Next-state decode from the state register, tr and pready
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = bus.tr ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!bus.pready) begin
                    state_d = ST_ACCESS;
                end else if (bus.tr) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE; // encoding 3 recovers to IDLE
        endcase
    end

    // Capture the request fields only when entering SETUP; otherwise hold
    always_comb begin
        paddr_d    = paddr_q;
        pdata_d    = pdata_q;
        pwrite_e_d = pwrite_e_q;
        if (state_d == ST_SETUP) begin
            paddr_d    = bus.addr;
            pdata_d    = bus.data;
            pwrite_e_d = bus.write_e;
        end
    end

    // State and bus registers; synchronous reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            paddr_q    <= '0;
            pdata_q    <= '0;
            pwrite_e_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pdata_q    <= pdata_d;
            pwrite_e_q <= pwrite_e_d;
        end
    end

    assign bus.present  = state_q;
    assign bus.next     = state_d;
    assign bus.penable  = (state_q == ST_ACCESS);
    assign bus.paddr    = paddr_q;
    assign bus.pdata    = pdata_q;
    assign bus.pwrite_e = pwrite_e_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: directed walk through the main scenarios, then random traffic.
// Expected values come from a transfer-level model that tracks phase and captured fields.
// psel is randomised to 0/1/X every cycle and never enters the model.
module tb_apb_master_fsm;

    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_master_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // model: phase 0 = no transfer, 1 = address phase, 2 = data phase
    int            m_phase;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pdata;
    logic          m_pwrite;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A transfer starts whenever the bus is free or just finishing, and tr is up.
    // The address phase always lasts one cycle; the data phase lasts until pready.
    function automatic int model_next(input int phase, input logic tr_i, input logic rdy_i);
        bit finishing;
        finishing = (phase == 2) && rdy_i;
        if (phase == 1)                            return 2;
        if (phase == 2 && !rdy_i)                  return 2;
        if ((phase == 0 || finishing) && tr_i)     return 1;
        return 0;
    endfunction

    task automatic model_edge();
        int nxt;
        nxt = model_next(m_phase, bus.tr, bus.pready);
        if (reset) begin
            m_phase  = 0;
            m_paddr  = '0;
            m_pdata  = '0;
            m_pwrite = 1'b0;
        end else begin
            if (nxt == 1) begin
                m_paddr  = bus.addr;
                m_pdata  = bus.data;
                m_pwrite = bus.write_e;
            end
            m_phase = nxt;
        end
    endtask

    task automatic rand_psel();
        case ($urandom_range(0, 2))
            0:       bus.psel = 1'b0;
            1:       bus.psel = 1'b1;
            default: bus.psel = 1'bx;
        endcase
    endtask

    // One clock: check the combinational next, take the edge, check registered outputs
    task automatic cycle(input bit chk_next);
        rand_psel();
        #1;
        if (chk_next)
            chk("next", 32'(bus.next), 32'(model_next(m_phase, bus.tr, bus.pready)));
        @(posedge clk);
        model_edge();
        #1;
        chk("present",  32'(bus.present),  32'(m_phase));
        chk("penable",  32'(bus.penable),  32'(m_phase == 2));
        chk("paddr",    32'(bus.paddr),    32'(m_paddr));
        chk("pdata",    32'(bus.pdata),    32'(m_pdata));
        chk("pwrite_e", 32'(bus.pwrite_e), 32'(m_pwrite));
    endtask

    initial begin
        m_phase  = 0;
        m_paddr  = '0;
        m_pdata  = '0;
        m_pwrite = 1'b0;

        // reset with request and ready both high
        reset = 1'b1; bus.tr = 1'b1; bus.pready = 1'b1;
        bus.addr = 8'h55; bus.data = 8'haa; bus.write_e = 1'b1; bus.psel = 1'b0;
        cycle(0);
        chk("rst_present", 32'(bus.present), 32'd0);
        chk("rst_paddr",   32'(bus.paddr),   32'd0);
        reset = 1'b0;
        #1;
        chk("rst_next", 32'(bus.next), 32'd1);

        // single write, no wait
        bus.addr = 8'h24; bus.data = 8'h81; bus.write_e = 1'b1; bus.pready = 1'b1;
        cycle(1);
        chk("wr_present", 32'(bus.present), 32'd1);
        chk("wr_paddr",   32'(bus.paddr),   32'h24);
        chk("wr_pdata",   32'(bus.pdata),   32'h81);
        cycle(1);
        chk("wr_penable", 32'(bus.penable), 32'd1);
        bus.tr = 1'b0;
        cycle(1);
        chk("wr_idle",    32'(bus.present), 32'd0);
        chk("wr_hold",    32'(bus.paddr),   32'h24);

        // wait states with an address change in the middle
        bus.tr = 1'b1; bus.addr = 8'h24;
        cycle(1);
        bus.tr = 1'b0; bus.pready = 1'b0;
        cycle(1);
        bus.addr = 8'h09; bus.tr = 1'b1;
        cycle(1);
        cycle(1);
        cycle(1);
        chk("ws_present", 32'(bus.present), 32'd2);
        chk("ws_paddr",   32'(bus.paddr),   32'h24);
        bus.tr = 1'b0; bus.pready = 1'b1;
        cycle(1);
        chk("ws_done",    32'(bus.present), 32'd0);

        // back-to-back transfers with fresh fields every cycle
        bus.tr = 1'b1; bus.pready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.addr = 8'(8'h30 + i); bus.data = 8'(8'hc0 + i); bus.write_e = i[0];
            cycle(1);
        end

        // reset while waiting in ACCESS
        bus.tr = 1'b0; bus.pready = 1'b1;
        cycle(1);
        cycle(1);
        bus.tr = 1'b1;
        cycle(1);
        bus.pready = 1'b0;
        cycle(1);
        chk("mid_access", 32'(bus.present), 32'd2);
        reset = 1'b1;
        cycle(1);
        chk("mid_rst",    32'(bus.present), 32'd0);
        chk("mid_rst_pd", 32'(bus.pdata),   32'd0);
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            bus.tr      = ($urandom_range(0, 2) != 0);
            bus.pready  = ($urandom_range(0, 2) != 0);
            bus.addr    = 8'($urandom);
            bus.data    = 8'($urandom);
            bus.write_e = 1'($urandom);
            cycle(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
